// File: rtl/hplvds_tx_serdes.sv
// hplvds_tx_serdes: parallel-to-serial LVDS transmitter with
// electrical-idle sequencing, link training and fill words.
module hplvds_tx_serdes #(
    parameter int WIDTH       = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TRAIN_WORDS = 4,
    parameter int IDLE_TO     = 32
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             EN_I,
    input  logic             POL_I,
    input  logic             FFE_EN_I,
    input  logic [WIDTH-1:0] DATA_I,
    input  logic             VALID_I,
    output logic             READY_O,
    output logic             DO_O,
    output logic             TX_EN_O,
    output logic             TX_VCM_EN_O,
    output logic             TX_EI_O,
    output logic             TX_FFE_O,
    output logic             TX_POL_O,
    output logic [2:0]       STATE_O
);

    localparam int TRAIN_LEN = TRAIN_WORDS * WIDTH;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam int FW = $clog2(IDLE_TO + 1);
    localparam int BW = $clog2(WIDTH);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TRAIN_LAST  = TW'(TRAIN_LEN - 1);
    localparam logic [FW-1:0] FILL_MAX    = FW'(IDLE_TO);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

    // Alternating 1,0,1,0... pattern, bit0 first on the wire
    localparam logic [2*WIDTH-1:0] REP  = {WIDTH{2'b01}};
    localparam logic [WIDTH-1:0]   FILL = REP[WIDTH-1:0];

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        SETTLE = 3'd1,
        EIDLE  = 3'd2,
        TRAIN  = 3'd3,
        DATA   = 3'd4
    } stateT;

    stateT            state, nState;
    logic [SW-1:0]    settleCnt, nSettle;
    logic [TW-1:0]    trainCnt, nTrain;
    logic [FW-1:0]    fillCnt, nFill;
    logic [BW-1:0]    bitCnt, nBit;
    logic [WIDTH-1:0] shiftReg, nShift;
    logic             nDo, firstBit, nActive, nFfe, wordEnd;

    assign wordEnd = (state == TRAIN && trainCnt == TRAIN_LAST) ||
                     (state == DATA && bitCnt == BIT_LAST);
    assign READY_O = wordEnd;
    assign STATE_O = state;

    always_comb begin
        nState   = state;
        nSettle  = settleCnt;
        nTrain   = trainCnt;
        nFill    = fillCnt;
        nBit     = bitCnt;
        nShift   = shiftReg;
        nDo      = 1'b0;
        firstBit = 1'b0;
        unique case (state)
            OFF: begin
                if (EN_I) begin
                    nState  = SETTLE;
                    nSettle = '0;
                end
            end
            SETTLE: begin
                if (settleCnt == SETTLE_LAST) begin
                    nState  = EIDLE;
                    nSettle = '0;
                end else begin
                    nSettle = settleCnt + 1'b1;
                end
            end
            EIDLE: begin
                if (VALID_I) begin
                    nState   = TRAIN;
                    nTrain   = '0;
                    nDo      = 1'b1;
                    firstBit = 1'b1;
                end
            end
            TRAIN: begin
                if (!wordEnd) begin
                    nTrain = trainCnt + 1'b1;
                    nDo    = ~nTrain[0];
                end
            end
            DATA: begin
                if (!wordEnd) begin
                    nBit   = bitCnt + 1'b1;
                    nDo    = shiftReg[0];
                    nShift = shiftReg >> 1;
                end
            end
            default: nState = OFF;
        endcase

        // Word boundary: next word, a fill word, or timeout to idle
        if (wordEnd) begin
            nBit   = '0;
            nTrain = '0;
            if (VALID_I) begin
                nState = DATA;
                nDo    = DATA_I[0];
                nShift = DATA_I >> 1;
                nFill  = '0;
            end else if (fillCnt == FILL_MAX) begin
                nState = EIDLE;
                nShift = '0;
                nFill  = '0;
            end else begin
                nState = DATA;
                nDo    = FILL[0];
                nShift = FILL >> 1;
                nFill  = fillCnt + 1'b1;
            end
        end

        if (!EN_I) begin
            nState  = OFF;
            nSettle = '0;
            nTrain  = '0;
            nFill   = '0;
            nBit    = '0;
            nShift  = '0;
            nDo     = 1'b0;
        end
    end

    assign nActive = (nState == TRAIN) || (nState == DATA);
    assign nFfe    = FFE_EN_I & ~firstBit & nActive & (nDo ~^ DO_O);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state       <= OFF;
            settleCnt   <= '0;
            trainCnt    <= '0;
            fillCnt     <= '0;
            bitCnt      <= '0;
            shiftReg    <= '0;
            DO_O        <= 1'b0;
            TX_EN_O     <= 1'b0;
            TX_VCM_EN_O <= 1'b0;
            TX_EI_O     <= 1'b1;
            TX_FFE_O    <= 1'b0;
            TX_POL_O    <= 1'b0;
        end else begin
            state       <= nState;
            settleCnt   <= nSettle;
            trainCnt    <= nTrain;
            fillCnt     <= nFill;
            bitCnt      <= nBit;
            shiftReg    <= nShift;
            DO_O        <= nDo;
            TX_EN_O     <= (nState != OFF);
            TX_VCM_EN_O <= (nState != OFF);
            TX_EI_O     <= ~nActive;
            TX_FFE_O    <= nFfe;
            if (state == OFF) TX_POL_O <= POL_I;
        end
    end

endmodule

// File: tb/tb_hplvds_tx_serdes.sv
// tb_hplvds_tx_serdes: scoreboard bench for the LVDS serializer,
// expected bits queued at word acceptance and popped per bit.
module tb_hplvds_tx_serdes;

    localparam int W  = 8;
    localparam int TL = 4 * W;

    logic         CLK_I = 1'b0;
    logic         RST_I = 1'b1;
    logic         EN_I = 1'b0;
    logic         POL_I = 1'b0;
    logic         FFE_EN_I = 1'b0;
    logic [W-1:0] DATA_I = '0;
    logic         VALID_I = 1'b0;
    logic         READY_O, DO_O, TX_EN_O, TX_VCM_EN_O;
    logic         TX_EI_O, TX_FFE_O, TX_POL_O;
    logic [2:0]   STATE_O;

    int   nTests = 0;
    int   nFail = 0;
    logic expQ[$];
    logic prevBit = 1'b0;
    logic polExp = 1'b0;

    hplvds_tx_serdes dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .POL_I(POL_I),
        .FFE_EN_I(FFE_EN_I), .DATA_I(DATA_I), .VALID_I(VALID_I),
        .READY_O(READY_O), .DO_O(DO_O), .TX_EN_O(TX_EN_O),
        .TX_VCM_EN_O(TX_VCM_EN_O), .TX_EI_O(TX_EI_O),
        .TX_FFE_O(TX_FFE_O), .TX_POL_O(TX_POL_O), .STATE_O(STATE_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic pushWord(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) expQ.push_back(d[i]);
    endtask

    task automatic pushFill();
        for (int i = 0; i < W; i++) expQ.push_back((i % 2) == 0);
    endtask

    task automatic chkOff(input string tag);
        chk({tag, "St"}, 32'(STATE_O), 0);
        chk({tag, "En"}, 32'(TX_EN_O), 0);
        chk({tag, "Vcm"}, 32'(TX_VCM_EN_O), 0);
        chk({tag, "Ei"}, 32'(TX_EI_O), 1);
        chk({tag, "Do"}, 32'(DO_O), 0);
        chk({tag, "Rdy"}, 32'(READY_O), 0);
    endtask

    task automatic waitState(input logic [2:0] s, input int budget);
        int n = 0;
        while (STATE_O != s && n < budget) begin
            tick();
            n++;
        end
        chk("waitState", 32'(STATE_O), 32'(s));
    endtask

    // Expects EIDLE with VALID_I high; DATA_I is the first word
    task automatic runTrain();
        logic e;
        for (int k = 0; k < TL; k++) begin
            tick();
            e = (k % 2) == 0;
            chk("trDo", 32'(DO_O), 32'(e));
            chk("trEi", 32'(TX_EI_O), 0);
            chk("trRdy", 32'(READY_O), 32'(k == TL - 1));
            chk("trSt", 32'(STATE_O), 3);
            if (k == 0) chk("trFfe0", 32'(TX_FFE_O), 0);
            prevBit = e;
            if (k == TL - 1) pushWord(DATA_I);
        end
    endtask

    task automatic runWord(input logic nv, input logic [W-1:0] nd,
                           input logic doFill, input int stopAt);
        logic e;
        for (int j = 0; j < W; j++) begin
            tick();
            if (expQ.size() == 0) begin
                chk("qEmpty", 1, 0);
                e = 1'b0;
            end else begin
                e = expQ.pop_front();
            end
            chk("do", 32'(DO_O), 32'(e));
            chk("ffe", 32'(TX_FFE_O), 32'(FFE_EN_I && (e == prevBit)));
            chk("rdy", 32'(READY_O), 32'(j == W - 1));
            chk("dSt", 32'(STATE_O), 4);
            chk("dEi", 32'(TX_EI_O), 0);
            chk("pol", 32'(TX_POL_O), 32'(polExp));
            prevBit = e;
            VALID_I = 1'b0;
            if (j == 3) POL_I = ~POL_I;
            if (j == stopAt) begin
                EN_I = 1'b0;
                return;
            end
            if (j == W - 1) begin
                VALID_I = nv;
                DATA_I  = nd;
                if (nv) pushWord(nd);
                else if (doFill) pushFill();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chkOff("rst");
        chk("rstFfe", 32'(TX_FFE_O), 0);
        chk("rstPol", 32'(TX_POL_O), 0);
        RST_I = 1'b0;
        POL_I = 1'b1;
        tick();
        chk("polOff", 32'(TX_POL_O), 1);
        polExp = 1'b1;

        EN_I = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("settleSt", 32'(STATE_O), 1);
            chk("settleEn", 32'(TX_EN_O), 1);
            chk("settleEi", 32'(TX_EI_O), 1);
            chk("settleDo", 32'(DO_O), 0);
        end
        tick();
        chk("eidleSt", 32'(STATE_O), 2);
        chk("eidleEi", 32'(TX_EI_O), 1);
        chk("eidleRdy", 32'(READY_O), 0);

        VALID_I = 1'b1;
        DATA_I  = 8'hA5;
        runTrain();
        FFE_EN_I = 1'b1;
        runWord(1'b1, 8'h00, 1'b0, -1);
        runWord(1'b1, 8'hFF, 1'b0, -1);
        runWord(1'b0, 8'h00, 1'b1, -1);
        repeat (31) runWord(1'b0, 8'h00, 1'b1, -1);
        runWord(1'b0, 8'h00, 1'b0, -1);
        tick();
        chk("toSt", 32'(STATE_O), 2);
        chk("toEi", 32'(TX_EI_O), 1);
        chk("toDo", 32'(DO_O), 0);
        chk("toFfe", 32'(TX_FFE_O), 0);
        chk("toQ", 32'(expQ.size()), 0);

        VALID_I = 1'b1;
        DATA_I  = 8'h3C;
        runTrain();
        runWord(1'b0, 8'h00, 1'b1, -1);
        repeat (31) runWord(1'b0, 8'h00, 1'b1, -1);
        runWord(1'b1, 8'h5A, 1'b0, -1);
        runWord(1'b0, 8'h00, 1'b1, -1);
        runWord(1'b0, 8'h00, 1'b0, 2);
        tick();
        chkOff("abort");
        expQ.delete();

        EN_I    = 1'b1;
        VALID_I = 1'b1;
        waitState(3'd3, 40);
        tick();
        tick();
        RST_I = 1'b1;
        tick();
        chkOff("rstTr");
        chk("rstTrPol", 32'(TX_POL_O), 0);
        chk("rstTrFfe", 32'(TX_FFE_O), 0);
        RST_I   = 1'b0;
        VALID_I = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("postRstDo", 32'(DO_O), 0);
            chk("postRstEi", 32'(TX_EI_O), 1);
        end
        chk("postRstSt", 32'(STATE_O), 2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
